// File: rtl/uart_hex_cmd_rx.sv
// 8N1 UART receiver feeding an ASCII-hex pair parser that emits command bytes.
// rx_done_o ~9.5 bit times after the start edge; cmd_valid_o one cycle later. No backpressure.
module uart_hex_cmd_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       rx_serial_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic [7:0] cmd_data_o,
  output logic       cmd_valid_o,
  output logic       parse_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;
  typedef enum logic {P_WAIT_HI, P_WAIT_LO} parse_st_t;

  logic            r_sync1, r_sync2;
  logic            w_rx;
  uart_st_t        r_ust;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_byte;
  logic            r_rx_done;
  logic            r_frame_err;

  parse_st_t       r_pst;
  logic [3:0]      r_hi;
  logic [7:0]      r_cmd_data;
  logic            r_cmd_valid;
  logic            r_parse_err;

  logic            w_is_hex;
  logic            w_is_sep;
  logic [3:0]      w_nib;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_serial_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ust       <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_byte   <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_ust)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) r_ust <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_ust     <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx;
            if (r_bit_idx == 3'd7) r_ust <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            r_ust <= S_IDLE;
            if (w_rx) begin
              r_rx_byte <= r_shift;
              r_rx_done <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_ust <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_is_hex = 1'b0;
    w_is_sep = 1'b0;
    w_nib    = 4'd0;
    if (r_rx_byte >= 8'h30 && r_rx_byte <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = r_rx_byte[3:0];
    end else if ((r_rx_byte >= 8'h41 && r_rx_byte <= 8'h46) ||
                 (r_rx_byte >= 8'h61 && r_rx_byte <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nib    = r_rx_byte[3:0] + 4'd9;
    end else if (r_rx_byte == 8'h20 || r_rx_byte == 8'h0D || r_rx_byte == 8'h0A) begin
      w_is_sep = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pst       <= P_WAIT_HI;
      r_hi        <= '0;
      r_cmd_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_parse_err <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_parse_err <= 1'b0;
      if (r_rx_done) begin
        case (r_pst)
          P_WAIT_HI: begin
            if (w_is_hex) begin
              r_hi  <= w_nib;
              r_pst <= P_WAIT_LO;
            end else if (!w_is_sep) begin
              r_parse_err <= 1'b1;
            end
          end
          P_WAIT_LO: begin
            r_pst <= P_WAIT_HI;
            if (w_is_hex) begin
              r_cmd_data  <= {r_hi, w_nib};
              r_cmd_valid <= 1'b1;
            end else begin
              r_parse_err <= 1'b1;
            end
          end
          default: r_pst <= P_WAIT_HI;
        endcase
      end
    end
  end

  assign rx_byte_o   = r_rx_byte;
  assign rx_done_o   = r_rx_done;
  assign frame_err_o = r_frame_err;
  assign cmd_data_o  = r_cmd_data;
  assign cmd_valid_o = r_cmd_valid;
  assign parse_err_o = r_parse_err;

endmodule
